// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 32-bit word memory port between instruction
// fetch and the load/store path. Data has priority, but a streak counter
// bounds how many back-to-back data grants can starve a waiting fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              a_rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_hold,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RUN_W  = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    // Registered memory command presented on the mem_* port for a whole access.
    typedef struct packed {
        logic              req;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             pick_data;
    logic             pick_fetch;

    // Arbitration: data wins unless fetch is waiting and the data streak is used up.
    assign pick_data  = d_req && (!if_req || (run_q < RUN_MAX));
    assign pick_fetch = !pick_data && if_req;

    // Both requesters see the memory read data; only the acked one samples it.
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign if_hold  = if_req && !if_ack;

    assign mem_req   = cmd_q.req;
    assign mem_we    = cmd_q.we;
    assign mem_be    = cmd_q.be;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    // State, streak counter and memory command registers.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cmd_q   <= cmd_d;
        end
    end

    // Next-state, grant sequencing and completion acks.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cmd_d   = cmd_q;
        if_ack  = 1'b0;
        d_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d     = BUSY_D;
                    cmd_d.req   = 1'b1;
                    cmd_d.we    = d_we;
                    cmd_d.be    = d_we ? d_be : {BE_W{1'b1}};
                    cmd_d.addr  = d_addr;
                    cmd_d.wdata = d_wdata;
                    if (!if_req) begin
                        run_d = '0;
                    end else if (run_q >= RUN_MAX) begin
                        run_d = RUN_MAX;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else if (pick_fetch) begin
                    state_d    = BUSY_IF;
                    cmd_d.req  = 1'b1;
                    cmd_d.we   = 1'b0;
                    cmd_d.be   = {BE_W{1'b1}};
                    cmd_d.addr = if_addr;
                    run_d      = '0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_ack    = 1'b1;
                    cmd_d.req = 1'b0;
                    cmd_d.we  = 1'b0;
                    state_d   = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_ack     = 1'b1;
                    cmd_d.req = 1'b0;
                    cmd_d.we  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              a_rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_hold;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int lat          = 0;
    bit mem_auto     = 1'b1;
    int wcnt         = 0;
    int ack_log[$];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_D_RUN(4)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_hold   (if_hold),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: raises mem_ready after lat wait cycles; read data = C0DE_0000 | addr.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (mem_req && !mem_ready) begin
                    if (wcnt >= lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = 32'hC0DE_0000 | 32'(mem_addr);
                        wcnt      = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wcnt      = 0;
                end
            end
        end
    end

    // Ack order log: 1 = fetch ack, 0 = data ack.
    always @(negedge clk) begin
        if (if_ack) ack_log.push_back(1);
        if (d_ack)  ack_log.push_back(0);
    end

    initial begin
        int n;
        logic [9:0] pat;

        a_rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mem_req",   32'(mem_req),   32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_be",    32'(mem_be),    32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_if_ack",    32'(if_ack),    32'h0);
        check("rst_d_ack",     32'(d_ack),     32'h0);
        check("rst_if_hold",   32'(if_hold),   32'h0);
        a_rst = 1'b1;

        // 1: fetch only, zero-wait memory
        @(posedge clk); #2; if_req = 1'b1; if_addr = 14'h0010;
        @(negedge clk);
        check("t1_hold_wait", 32'(if_hold), 32'h1);
        check("t1_idle_req",  32'(mem_req), 32'h0);
        @(negedge clk);
        check("t1_mem_req",  32'(mem_req),  32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0010);
        check("t1_mem_be",   32'(mem_be),   32'hF);
        check("t1_mem_we",   32'(mem_we),   32'h0);
        check("t1_if_ack",   32'(if_ack),   32'h1);
        check("t1_d_ack",    32'(d_ack),    32'h0);
        check("t1_if_rdata", if_rdata,      32'hC0DE_0010);
        check("t1_hold_ack", 32'(if_hold),  32'h0);
        @(posedge clk); #2; if_req = 1'b0;
        @(negedge clk);
        check("t1_ack_once", 32'(if_ack),  32'h0);
        check("t1_req_drop", 32'(mem_req), 32'h0);
        check("t1_hold_idle", 32'(if_hold), 32'h0);

        // 2: simultaneous requests, data first then fetch
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 14'h0200; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 14'h0040;
        @(negedge clk);
        @(negedge clk);
        check("t2_d_req",    32'(mem_req),  32'h1);
        check("t2_d_we",     32'(mem_we),   32'h1);
        check("t2_d_be",     32'(mem_be),   32'h3);
        check("t2_d_addr",   32'(mem_addr), 32'h0200);
        check("t2_d_wdata",  mem_wdata,     32'hDEAD_BEEF);
        check("t2_d_ack",    32'(d_ack),    32'h1);
        check("t2_no_if_ack", 32'(if_ack),  32'h0);
        check("t2_if_hold",  32'(if_hold),  32'h1);
        @(posedge clk); #2; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("t2_gap_req",  32'(mem_req), 32'h0);
        check("t2_gap_hold", 32'(if_hold), 32'h1);
        @(negedge clk);
        check("t2_f_req",    32'(mem_req),  32'h1);
        check("t2_f_addr",   32'(mem_addr), 32'h0040);
        check("t2_f_we",     32'(mem_we),   32'h0);
        check("t2_f_be",     32'(mem_be),   32'hF);
        check("t2_f_ack",    32'(if_ack),   32'h1);
        check("t2_f_rdata",  if_rdata,      32'hC0DE_0040);
        @(posedge clk); #2; if_req = 1'b0;

        // 3: both held, streak limit 4 -> D D D D F repeating
        ack_log.delete();
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 14'h0300;
        if_req = 1'b1; if_addr = 14'h0050;
        n = 0;
        while (ack_log.size() < 10 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("t3_timeout", 32'(ack_log.size() >= 10), 32'h1);
        @(posedge clk); #2; d_req = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < ack_log.size()) pat[i] = (ack_log[i] == 1);
        end
        check("t3_pattern",  32'(pat),            32'h210);
        check("t3_no_extra", 32'(ack_log.size()), 32'd10);

        // 4: 3 wait-state read, command stable until ready
        lat = 3;
        @(posedge clk); #2; d_req = 1'b1; d_we = 1'b0; d_be = 4'b0001; d_addr = 14'h0155;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t4_req_c%0d", c),  32'(mem_req),  32'h1);
            check($sformatf("t4_addr_c%0d", c), 32'(mem_addr), 32'h0155);
            check($sformatf("t4_ack_c%0d", c),  32'(d_ack),    (c == 3) ? 32'h1 : 32'h0);
        end
        check("t4_rdata", d_rdata,       32'hC0DE_0155);
        check("t4_be",    32'(mem_be),   32'hF);
        check("t4_we",    32'(mem_we),   32'h0);
        @(posedge clk); #2; d_req = 1'b0; lat = 0;
        @(negedge clk);
        check("t4_done_req", 32'(mem_req), 32'h0);
        check("t4_done_ack", 32'(d_ack),   32'h0);

        // 4b: spurious mem_ready while idle
        @(posedge clk); #2; mem_auto = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        repeat (2) begin
            @(negedge clk);
            check("sp_if_ack",  32'(if_ack),  32'h0);
            check("sp_d_ack",   32'(d_ack),   32'h0);
            check("sp_mem_req", 32'(mem_req), 32'h0);
        end
        @(posedge clk); #2; mem_ready = 1'b0; mem_auto = 1'b1;

        // 5: reset in BUSY_D after a 3-long data streak
        ack_log.delete();
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 14'h00AA; d_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 14'h0060;
        n = 0;
        while (ack_log.size() < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("t5_pre_timeout", 32'(ack_log.size()), 32'd3);
        lat = 3;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_req",  32'(mem_req),  32'h1);
        check("t5_busy_addr", 32'(mem_addr), 32'h00AA);
        check("t5_busy_ack",  32'(d_ack),    32'h0);
        #2; a_rst = 1'b0;
        #1;
        check("t5_rst_req",  32'(mem_req),  32'h0);
        check("t5_rst_ack",  32'(d_ack),    32'h0);
        check("t5_rst_addr", 32'(mem_addr), 32'h0);
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            check("t5_rst_d_ack",  32'(d_ack),  32'h0);
            check("t5_rst_if_ack", 32'(if_ack), 32'h0);
        end
        #1; a_rst = 1'b1;
        @(negedge clk);
        check("t5_regrant_req",  32'(mem_req),  32'h1);
        check("t5_regrant_we",   32'(mem_we),   32'h1);
        check("t5_regrant_addr", 32'(mem_addr), 32'h00AA);
        check("t5_regrant_ack",  32'(d_ack),    32'h1);
        @(posedge clk); #2; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_fetch_ack",  32'(if_ack),   32'h1);
        check("t5_fetch_addr", 32'(mem_addr), 32'h0060);
        @(posedge clk); #2; if_req = 1'b0;
        @(negedge clk); #1;
        check("t5_log_size", 32'(ack_log.size()), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
